bnn_host_seq: RTL and testbench
===============================

BNN_HOST_SEQ -- requirements
Module: bnn_host_seq

Interface
REQ-001 Parameters SHALL be: O_CH 64, number of output channels; DATA_W 9, width of weight/activation words; OUT_ROW_LENGTH 4, sign bits per channel; PE_LAT 1, PE column latency in cycles; CNT_W 8, width of config counters.
REQ-002 Clocking SHALL be one clock; reset SHALL be asynchronous, active-low.
REQ-003 Port clk_in: input, 1 bit; sole clock, rising edge.
REQ-004 Port rst_in: input, 1 bit; asynchronous active-low reset.
REQ-005 Port start_in: input, 1 bit; job start, sampled only in IDLE.
REQ-006 Port abort_in: input, 1 bit; return to IDLE on the next cycle.
REQ-007 Port cfg_rows_in: input, CNT_W bits; number of row passes, sampled with start_in.
REQ-008 Port cfg_act_len_in: input, CNT_W bits; activations per row pass, sampled with start_in.
REQ-009 Port src_data_in: input, DATA_W bits; weight or activation word.
REQ-010 Port src_valid_in / src_ready_out: input / output, 1 bit each; a source word transfers when both are high.
REQ-011 Port data_out: output, DATA_W bits; word to the compute array.
REQ-012 Port load_weight_out, in_valid_out, pop_out: outputs, 1 bit each; array control strobes.
REQ-013 Port array_rst_out: output, 1 bit; active-low synchronous psum clear to the array.
REQ-014 Port sum_in: input, OUT_ROW_LENGTH bits; sign bits returned by the array.
REQ-015 Port res_data_out, res_ch_out, res_valid_out: outputs, OUT_ROW_LENGTH, 6 and 1 bits; result stream, no backpressure.
REQ-016 Port busy_out, done_out: outputs, 1 bit each; busy = state not IDLE; done = 1-cycle pulse at job end.

Function
REQ-017 FSM states SHALL be IDLE, GATHER_W, LOAD_W, CLEAR, STREAM, DRAIN, POP, DONE.
REQ-018 IDLE SHALL go to GATHER_W on start_in; if cfg_rows_in==0, it SHALL go directly to DONE.
REQ-019 GATHER_W SHALL accept exactly O_CH source words (ready high) into the weight buffer, index 0 first, tolerating valid gaps.
REQ-020 LOAD_W SHALL drive load_weight_out high for exactly O_CH consecutive cycles with data_out = buffer[k] in cycle k, with no gaps.
REQ-021 CLEAR SHALL last 1 cycle with array_rst_out=0; array_rst_out SHALL be 1 in every other state except reset.
REQ-022 STREAM SHALL pass cfg_act_len words: in_valid_out = src_valid_in, data_out = src_data_in, src_ready_out=1; gaps allowed; cfg_act_len 0 skips STREAM.
REQ-023 data_out SHALL be 0 whenever neither load_weight_out nor in_valid_out is high.
REQ-024 DRAIN SHALL wait exactly O_CH+PE_LAT cycles after the last accepted activation.
REQ-025 POP SHALL drive pop_out high for O_CH consecutive cycles; in pop cycle k, sum_in belongs to channel k.
REQ-026 The result stream SHALL register sum_in in pop cycle k, giving res_valid_out=1, res_ch_out=k and res_data_out=sum_in one cycle later.
REQ-027 After POP, the FSM SHALL go to CLEAR if rows remain (weights are retained; no reload), else to DONE.
REQ-028 DONE SHALL last 1 cycle with done_out=1, then go to IDLE.
REQ-029 src_ready_out SHALL be 0 outside GATHER_W and STREAM.
REQ-030 abort_in SHALL have priority over every transition: next state IDLE, all strobes 0, counters cleared, array_rst_out pulsed 0 for one cycle; done_out SHALL NOT pulse.
REQ-031 start_in outside IDLE SHALL be ignored.

Reset
REQ-032 While rst_in=0: state IDLE; array_rst_out=0; every other output 0; all counters 0.
REQ-033 Weight buffer contents SHALL NOT be reset.
REQ-034 Reset mid-job SHALL abandon the job; there SHALL be no partial result on the result stream afterwards.

Structure
REQ-035 Package bnn_host_pkg SHALL hold the state enum, O_CH, DATA_W, OUT_ROW_LENGTH, PE_LAT and CNT_W.
REQ-036 Sub-module bnn_weight_buf SHALL be an O_CH x DATA_W register file with one write port and one read port, read combinational by index.

Verification
REQ-037 rows=1, act_len=3, weights 0..63 with random valid gaps -> load_weight_out high 64 consecutive cycles with data_out 0..63; then 1 clear cycle; 3 in_valid_out pulses; 65-cycle drain; 64 results with ch 0..63 and res_data equal to the model sum_in.
REQ-038 rows=3, act_len=2 -> no second LOAD_W; 3 CLEAR pulses; 192 results; done_out pulses once.
REQ-039 cfg_rows_in=0 -> IDLE, DONE, IDLE; no strobes; done_out=1 for 1 cycle.
REQ-040 abort_in in cycle 10 of POP -> IDLE next cycle, pop_out=0, 11 results total, no done_out, a single array_rst_out low pulse.
REQ-041 rst_in low during STREAM -> all outputs 0 and array_rst_out 0 immediately; after release, a new start with act_len=0 completes with 64 results.

Source files
------------

// File: rtl/bnn_host_pkg.sv
// Shared definitions for the BNN host sequencer: array geometry, counter
// width and the job-sequencing state encoding.
package bnn_host_pkg;

  localparam int O_CH           = 64;
  localparam int DATA_W         = 9;
  localparam int OUT_ROW_LENGTH = 4;
  localparam int PE_LAT         = 1;
  localparam int CNT_W          = 8;

  typedef enum logic [2:0] {
    IDLE,
    GATHER_W,
    LOAD_W,
    CLEAR,
    STREAM,
    DRAIN,
    POP,
    DONE
  } state_e;

endpackage

// File: rtl/bnn_weight_buf.sv
// Per-channel weight store: one synchronous write port, one combinational
// read port. Contents survive reset so a job can reuse weights across rows.
module bnn_weight_buf #(
  parameter int DEPTH = bnn_host_pkg::O_CH,
  parameter int WIDTH = bnn_host_pkg::DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bnn_host_seq.sv
// Host-side job sequencer for the BNN compute array: gathers weights, loads
// them once, then runs clear/stream/drain/pop passes per row.
module bnn_host_seq #(
  parameter int O_CH           = bnn_host_pkg::O_CH,
  parameter int DATA_W         = bnn_host_pkg::DATA_W,
  parameter int OUT_ROW_LENGTH = bnn_host_pkg::OUT_ROW_LENGTH,
  parameter int PE_LAT         = bnn_host_pkg::PE_LAT,
  parameter int CNT_W          = bnn_host_pkg::CNT_W
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic                      abort_in,
  input  logic [CNT_W-1:0]          cfg_rows_in,
  input  logic [CNT_W-1:0]          cfg_act_len_in,
  input  logic [DATA_W-1:0]         src_data_in,
  input  logic                      src_valid_in,
  output logic                      src_ready_out,
  output logic [DATA_W-1:0]         data_out,
  output logic                      load_weight_out,
  output logic                      in_valid_out,
  output logic                      pop_out,
  output logic                      array_rst_out,
  input  logic [OUT_ROW_LENGTH-1:0] sum_in,
  output logic [OUT_ROW_LENGTH-1:0] res_data_out,
  output logic [5:0]                res_ch_out,
  output logic                      res_valid_out,
  output logic                      busy_out,
  output logic                      done_out
);

  import bnn_host_pkg::*;

  localparam int IDX_W = $clog2(O_CH);
  localparam logic [CNT_W-1:0] LAST_CH    = CNT_W'(O_CH - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(O_CH + PE_LAT - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          rows_q, rows_d;
  logic [CNT_W-1:0]          actLen_q, actLen_d;
  logic [CNT_W-1:0]          cntInc;
  logic                      arrayRstN_q;
  logic [OUT_ROW_LENGTH-1:0] resData_q;
  logic [5:0]                resCh_q;
  logic                      resValid_q;
  logic                      bufWe;
  logic [DATA_W-1:0]         bufRdata;

  // The shared counter is the buffer index in both GATHER_W and LOAD_W.
  bnn_weight_buf #(
    .DEPTH (O_CH),
    .WIDTH (DATA_W)
  ) u_weight_buf (
    .clk_i   (clk_in),
    .we_i    (bufWe),
    .waddr_i (cnt_q[IDX_W-1:0]),
    .wdata_i (src_data_in),
    .raddr_i (cnt_q[IDX_W-1:0]),
    .rdata_o (bufRdata)
  );

  assign cntInc = cnt_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rows_d          = rows_q;
    actLen_d        = actLen_q;
    src_ready_out   = 1'b0;
    load_weight_out = 1'b0;
    in_valid_out    = 1'b0;
    pop_out         = 1'b0;
    data_out        = '0;
    done_out        = 1'b0;
    bufWe           = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          rows_d   = cfg_rows_in;
          actLen_d = cfg_act_len_in;
          cnt_d    = '0;
          state_d  = (cfg_rows_in == '0) ? DONE : GATHER_W;
        end
      end
      GATHER_W: begin
        src_ready_out = 1'b1;
        if (src_valid_in) begin
          bufWe = 1'b1;
          cnt_d = cntInc;
          if (cnt_q == LAST_CH) begin
            cnt_d   = '0;
            state_d = LOAD_W;
          end
        end
      end
      LOAD_W: begin
        load_weight_out = 1'b1;
        data_out        = bufRdata;
        cnt_d           = cntInc;
        if (cnt_q == LAST_CH) begin
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = (actLen_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        src_ready_out = 1'b1;
        in_valid_out  = src_valid_in;
        if (src_valid_in) begin
          data_out = src_data_in;
          cnt_d    = cntInc;
          if (cntInc == actLen_q) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        cnt_d = cntInc;
        if (cnt_q == LAST_DRAIN) begin
          cnt_d   = '0;
          state_d = POP;
        end
      end
      POP: begin
        pop_out = 1'b1;
        cnt_d   = cntInc;
        if (cnt_q == LAST_CH) begin
          cnt_d   = '0;
          rows_d  = rows_q - 1'b1;
          state_d = (rows_q == CNT_W'(1)) ? DONE : CLEAR;
        end
      end
      DONE: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every transition and suppresses the completion pulse.
    if (abort_in) begin
      state_d  = IDLE;
      cnt_d    = '0;
      rows_d   = '0;
      actLen_d = '0;
      done_out = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rows_q      <= '0;
      actLen_q    <= '0;
      arrayRstN_q <= 1'b0;
      resValid_q  <= 1'b0;
      resCh_q     <= '0;
      resData_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rows_q      <= rows_d;
      actLen_q    <= actLen_d;
      arrayRstN_q <= ~abort_in;
      resValid_q  <= pop_out;
      resCh_q     <= pop_out ? cnt_q[5:0] : 6'd0;
      resData_q   <= pop_out ? sum_in : '0;
    end
  end

  // Low during reset, in CLEAR, and for the cycle following an abort.
  assign array_rst_out = arrayRstN_q & (state_q != CLEAR);
  assign busy_out      = (state_q != IDLE);
  assign res_valid_out = resValid_q;
  assign res_ch_out    = resCh_q;
  assign res_data_out  = resData_q;

endmodule

// File: tb/tb_bnn_host_seq.sv
// Self-checking bench for bnn_host_seq: a source driver, an array model that
// feeds sum_in, and a result scoreboard keyed on pop cycles.
module tb_bnn_host_seq;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       start_in = 1'b0;
  logic       abort_in = 1'b0;
  logic [7:0] cfg_rows_in = '0;
  logic [7:0] cfg_act_len_in = '0;
  logic [8:0] src_data_in = '0;
  logic       src_valid_in = 1'b0;
  logic       src_ready_out;
  logic [8:0] data_out;
  logic       load_weight_out, in_valid_out, pop_out, array_rst_out;
  logic [3:0] sum_in = '0;
  logic [3:0] res_data_out;
  logic [5:0] res_ch_out;
  logic       res_valid_out, busy_out, done_out;

  int total = 0;
  int bad = 0;

  logic [8:0] wQ [$];
  logic [9:0] resQ [$];
  logic [9:0] expRes;

  int cyc = 0;
  int loadCount, loadRun, loadMax, actCount, popCount, resCount;
  int doneCount, busyCount, rstLowCount, zeroViol, readyViol;
  int lastActCyc, firstPopCyc;

  bnn_host_seq dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .abort_in        (abort_in),
    .cfg_rows_in     (cfg_rows_in),
    .cfg_act_len_in  (cfg_act_len_in),
    .src_data_in     (src_data_in),
    .src_valid_in    (src_valid_in),
    .src_ready_out   (src_ready_out),
    .data_out        (data_out),
    .load_weight_out (load_weight_out),
    .in_valid_out    (in_valid_out),
    .pop_out         (pop_out),
    .array_rst_out   (array_rst_out),
    .sum_in          (sum_in),
    .res_data_out    (res_data_out),
    .res_ch_out      (res_ch_out),
    .res_valid_out   (res_valid_out),
    .busy_out        (busy_out),
    .done_out        (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic clearCounters();
    loadCount = 0; loadRun = 0; loadMax = 0; actCount = 0; popCount = 0;
    resCount = 0; doneCount = 0; busyCount = 0; rstLowCount = 0;
    zeroViol = 0; readyViol = 0; lastActCyc = -1; firstPopCyc = -1;
  endtask

  // Pulses start for one cycle; returns on the following falling edge.
  task automatic applyStimulus(input int rows, input int actLen);
    @(negedge clk_in);
    cfg_rows_in    = 8'(rows);
    cfg_act_len_in = 8'(actLen);
    start_in       = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  // Offers n words with random valid gaps; the first 64 are weights.
  task automatic sendWords(input int n, input bit ramp);
    int sent;
    int tries;
    logic [8:0] w;
    sent = 0;
    tries = 0;
    while (sent < n && tries < 5000) begin
      w = (ramp && sent < 64) ? 9'(sent) : 9'($urandom);
      src_valid_in = ($urandom_range(0, 3) != 0);
      src_data_in  = w;
      #2;
      if (src_valid_in && src_ready_out) begin
        if (sent < 64) wQ.push_back(w);
        sent++;
      end
      @(negedge clk_in);
      tries++;
    end
    src_valid_in = 1'b0;
    src_data_in  = '0;
    checkOutput("words_sent", sent, n);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    #2;
    while (busy_out && n < budget) begin
      @(negedge clk_in);
      #2;
      n++;
    end
    checkOutput("idle_reached", busy_out, 0);
  endtask

  // Monitor and array model: samples between edges, drives sum_in for the next edge.
  always begin
    @(negedge clk_in);
    #1;
    cyc++;
    if (rst_in) begin
      sum_in = 4'($urandom);
      if (res_valid_out) begin
        if (resQ.size() == 0) begin
          checkOutput("result_unexpected", res_valid_out, 0);
        end else begin
          expRes = resQ.pop_front();
          checkOutput("res_ch", res_ch_out, expRes[9:4]);
          checkOutput("res_data", res_data_out, expRes[3:0]);
        end
        resCount++;
      end
      if (load_weight_out) begin
        if (wQ.size() == 0) checkOutput("weight_unexpected", load_weight_out, 0);
        else checkOutput("weight_data", data_out, wQ.pop_front());
        loadCount++;
        loadRun++;
        if (loadRun > loadMax) loadMax = loadRun;
      end else begin
        loadRun = 0;
      end
      if (in_valid_out) begin
        checkOutput("act_data", data_out, src_data_in);
        actCount++;
        lastActCyc = cyc;
      end
      if (!load_weight_out && !in_valid_out && data_out != '0) zeroViol++;
      if (src_ready_out && (!busy_out || load_weight_out || pop_out)) readyViol++;
      if (pop_out) begin
        if (firstPopCyc < 0) firstPopCyc = cyc;
        resQ.push_back({6'(popCount % 64), sum_in});
        popCount++;
      end
      if (!array_rst_out) rstLowCount++;
      if (done_out) doneCount++;
      if (busy_out) busyCount++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    clearCounters();
    repeat (3) @(negedge clk_in);
    #1;
    checkOutput("reset_outputs", {busy_out, done_out, src_ready_out, load_weight_out, in_valid_out,
                pop_out, array_rst_out, res_valid_out, data_out, res_data_out, res_ch_out}, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    clearCounters();

    $display("[TB] job: rows=1 act_len=3, ramp weights");
    applyStimulus(1, 3);
    sendWords(67, 1'b1);
    waitIdle(2000);
    checkOutput("a_loads", loadCount, 64);
    checkOutput("a_load_run", loadMax, 64);
    checkOutput("a_clear", rstLowCount, 1);
    checkOutput("a_acts", actCount, 3);
    checkOutput("a_drain", firstPopCyc - lastActCyc - 1, 65);
    checkOutput("a_results", resCount, 64);
    checkOutput("a_done", doneCount, 1);
    checkOutput("a_data_idle_zero", zeroViol, 0);
    checkOutput("a_ready_idle", readyViol, 0);
    checkOutput("a_res_q_empty", resQ.size(), 0);
    checkOutput("a_w_q_empty", wQ.size(), 0);
    clearCounters();

    $display("[TB] job: rows=3 act_len=2, stray start mid-job");
    applyStimulus(3, 2);
    sendWords(70, 1'b0);
    cfg_rows_in = 8'd0;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    waitIdle(2000);
    checkOutput("b_loads", loadCount, 64);
    checkOutput("b_clear", rstLowCount, 3);
    checkOutput("b_acts", actCount, 6);
    checkOutput("b_results", resCount, 192);
    checkOutput("b_done", doneCount, 1);
    checkOutput("b_data_idle_zero", zeroViol, 0);
    checkOutput("b_ready_idle", readyViol, 0);
    clearCounters();

    $display("[TB] job: rows=0");
    applyStimulus(0, 5);
    waitIdle(20);
    checkOutput("c_busy_cycles", busyCount, 1);
    checkOutput("c_done", doneCount, 1);
    checkOutput("c_strobes", loadCount + actCount + popCount, 0);
    checkOutput("c_clear", rstLowCount, 0);
    clearCounters();

    $display("[TB] job: abort in pop cycle 10");
    applyStimulus(1, 1);
    sendWords(65, 1'b0);
    n = 0;
    #2;
    while (popCount < 11 && n < 500) begin
      @(negedge clk_in);
      #2;
      n++;
    end
    checkOutput("d_pop_reached", popCount, 11);
    abort_in = 1'b1;
    @(negedge clk_in);
    abort_in = 1'b0;
    #2;
    checkOutput("d_idle_after_abort", busy_out, 0);
    checkOutput("d_pop_after_abort", pop_out, 0);
    repeat (4) @(negedge clk_in);
    #2;
    checkOutput("d_results", resCount, 11);
    checkOutput("d_done", doneCount, 0);
    checkOutput("d_rst_pulses", rstLowCount, 2);
    checkOutput("d_res_q_empty", resQ.size(), 0);
    clearCounters();

    $display("[TB] job: reset during stream, then act_len=0");
    @(negedge clk_in);
    applyStimulus(1, 5);
    sendWords(66, 1'b0);
    #2;
    rst_in = 1'b0;
    #1;
    checkOutput("e_reset_outputs", {busy_out, done_out, src_ready_out, load_weight_out, in_valid_out,
                pop_out, array_rst_out, res_valid_out, data_out, res_data_out, res_ch_out}, 0);
    checkOutput("e_acts_before_reset", actCount, 2);
    checkOutput("e_no_pending", resQ.size() + wQ.size(), 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    clearCounters();
    applyStimulus(1, 0);
    sendWords(64, 1'b0);
    waitIdle(2000);
    checkOutput("e_loads", loadCount, 64);
    checkOutput("e_acts", actCount, 0);
    checkOutput("e_results", resCount, 64);
    checkOutput("e_done", doneCount, 1);
    checkOutput("e_res_q_empty", resQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
